// File: rtl/counter_cmd_pkg.sv
// Shared definitions for the counter command front end.
// Command encoding follows the counter's priority order: a larger code wins.
package counter_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_CLEAR = 2'd1,
    CMD_INC   = 2'd2,
    CMD_LOAD  = 2'd3
  } cmd_t;

  // Debounce counter width: must hold 0 .. cycles-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles <= 2) return 1;
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/counter_cmd_ctrl_btn_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce counter and
// rising-edge detect. The rise pulse is registered on the same edge that
// sets db, so the command stage sees it one cycle after db changes.
module btn_debounce
  import counter_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronize raw input, then require CNT_LAST+1 consecutive mismatching
  // samples before db follows; any agreement restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != db) begin
        if (cnt == CNT_LAST) begin
          db   <= sync2;
          cnt  <= '0;
          rise <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Counter command front end: debounces three buttons, synchronizes the
// switch bank and issues at most one registered command pulse per clock in
// the counter's priority order (load > inc > clear).
// Build option: define COUNTER_CMD_AUTO_REPEAT_EN to enable auto-repeat of
// inc while the inc button stays held. Without it the repeat timer is held
// in reset and folds away, leaving one inc per press.
module counter_cmd_ctrl
  import counter_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_inc,
  input  logic       btn_load,
  input  logic       btn_clr,
  input  logic [3:0] sw,
  output logic       inc,
  output logic       load,
  output logic       clear,
  output logic [3:0] load_val,
  output logic       cmd_drop
);

`ifdef COUNTER_CMD_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  localparam logic [15:0] HOLD_RELOAD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REPEAT_RELOAD = 16'(REPEAT_CYCLES - 1);

  logic       db_inc, db_load, db_clr;
  logic       rise_inc, rise_load, rise_clr;
  logic [3:0] sw_s1, sw_s2;
  logic       rep_active;
  logic [15:0] rep_timer;
  logic       rep_req;
  logic       inc_req, load_req, clr_req;
  cmd_t       win;
  logic       drop;
  logic       unused_db;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clock (clock),
    .reset (reset),
    .raw   (btn_inc),
    .db    (db_inc),
    .rise  (rise_inc)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clock (clock),
    .reset (reset),
    .raw   (btn_load),
    .db    (db_load),
    .rise  (rise_load)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clock (clock),
    .reset (reset),
    .raw   (btn_clr),
    .db    (db_clr),
    .rise  (rise_clr)
  );

  // Only the inc level matters (for repeat); the others exist for debug taps.
  assign unused_db = db_load ^ db_clr;

  // Per-bit 2-flop synchronizer for the switch bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // Repeat timer: armed by the initial inc request, first fires after the
  // hold delay, then every repeat period; dropped the moment db_inc falls.
  always_ff @(posedge clock) begin
    if (reset || !db_inc || !AUTO_REPEAT) begin
      rep_active <= 1'b0;
      rep_timer  <= '0;
    end else if (rise_inc) begin
      rep_active <= 1'b1;
      rep_timer  <= HOLD_RELOAD;
    end else if (rep_active) begin
      if (rep_timer == '0) rep_timer <= REPEAT_RELOAD;
      else                 rep_timer <= rep_timer - 1'b1;
    end
  end

  assign rep_req  = rep_active && db_inc && (rep_timer == '0);
  assign inc_req  = rise_inc || rep_req;
  assign load_req = rise_load;
  assign clr_req  = rise_clr;

  // Fixed-priority pick of a single winner; any other live request is lost.
  always_comb begin
    win = CMD_NONE;
    if (load_req)     win = CMD_LOAD;
    else if (inc_req) win = CMD_INC;
    else if (clr_req) win = CMD_CLEAR;
    drop = (load_req && (inc_req || clr_req)) || (inc_req && clr_req);
  end

  // Registered command outputs; load_val captures the switches only on load.
  always_ff @(posedge clock) begin
    if (reset) begin
      inc      <= 1'b0;
      load     <= 1'b0;
      clear    <= 1'b0;
      cmd_drop <= 1'b0;
      load_val <= '0;
    end else begin
      inc      <= (win == CMD_INC);
      load     <= (win == CMD_LOAD);
      clear    <= (win == CMD_CLEAR);
      cmd_drop <= drop;
      if (win == CMD_LOAD) load_val <= sw_s2;
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl with default parameters
// (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8).
// Inputs change 1 time unit after a rising edge; "step i" is the i-th edge
// after a change, and outputs are sampled 1 time unit after that edge.
module tb_counter_cmd_ctrl;

`ifdef COUNTER_CMD_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_load = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       inc, load, clear, cmd_drop;
  logic [3:0] load_val;

  int vectors = 0;
  int errors  = 0;

  counter_cmd_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .btn_inc  (btn_inc),
    .btn_load (btn_load),
    .btn_clr  (btn_clr),
    .sw       (sw),
    .inc      (inc),
    .load     (load),
    .clear    (clear),
    .load_val (load_val),
    .cmd_drop (cmd_drop)
  );

  always #5 clock = ~clock;

  task automatic step(input bit ei, input bit el, input bit ec, input bit ed,
                      input string tag, input int idx);
    logic [3:0] obs;
    logic [3:0] exp;
    @(posedge clock);
    #1;
    obs = {inc, load, clear, cmd_drop};
    exp = {ei, el, ec, ed};
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: inc/load/clear/drop observed %b expected %b",
             tag, idx, obs, exp);
    end
  endtask

  task automatic chk_val(input logic [3:0] exp, input string tag);
    vectors++;
    assert (load_val === exp) else begin
      errors++;
      $error("FAIL %s: load_val observed %h expected %h", tag, load_val, exp);
    end
  endtask

  initial begin
    bit seen_db;

    // Reset state
    step(0, 0, 0, 0, "reset", 0);
    chk_val(4'h0, "reset_load_val");
    reset = 1'b0;

    // Clean press: held 20 cycles, single inc after 7th edge
    // (with auto-repeat, one extra at t0+16 before db_inc falls at step 26).
    btn_inc = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 21) btn_inc = 1'b0;
      step((i == 7) || (REP && i == 23), 0, 0, 0, "clean_press", i);
    end

    // Bounce on load with sw=A; stable hold starts at step 9 -> pulse at 15.
    sw = 4'hA;
    for (int i = 1; i <= 20; i++) begin
      btn_load = (i <= 8) ? (((i - 1) / 2) % 2 == 0) : 1'b1;
      step(0, (i == 15), 0, 0, "bounce", i);
    end
    chk_val(4'hA, "bounce_load_val");
    sw = 4'h3;
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, "sw_change", i);
    chk_val(4'hA, "load_val_hold");
    btn_load = 1'b0;
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, "load_release", i);
    chk_val(4'hA, "load_val_after_release");

    // Simultaneous press: load wins, drop flagged in the same cycle.
    btn_inc = 1'b1; btn_load = 1'b1; btn_clr = 1'b1;
    for (int i = 1; i <= 10; i++) step(0, (i == 7), 0, (i == 7), "simul", i);
    chk_val(4'h3, "simul_load_val");
    btn_inc = 1'b0; btn_load = 1'b0; btn_clr = 1'b0;
    for (int i = 1; i <= 12; i++) step(0, 0, 0, 0, "simul_release", i);

    // Reset while clear is mid-debounce (cnt=2 after step 4).
    btn_clr = 1'b1;
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, "pre_reset", i);
    reset = 1'b1;
    step(0, 0, 0, 0, "mid_reset", 0);
    chk_val(4'h0, "mid_reset_load_val");
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) step(0, 0, (i == 7), 0, "post_reset", i);
    btn_clr = 1'b0;
    for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, "clr_release", i);

    // Glitch of 3 cycles on clear: no pulse, debounced state never set.
    seen_db = 1'b0;
    btn_clr = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) btn_clr = 1'b0;
      step(0, 0, 0, 0, "glitch", i);
      seen_db = seen_db | dut.u_db_clr.db;
    end
    vectors++;
    assert (seen_db === 1'b0) else begin
      errors++;
      $error("FAIL glitch_db: db_clr observed %b expected %b", seen_db, 1'b0);
    end

    // Long hold of inc (50 cycles): one pulse, or t0,+16,+24,+32,+40,+48.
    btn_inc = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      if (i == 51) btn_inc = 1'b0;
      step((i == 7) || (REP && i >= 23 && i <= 55 && ((i - 23) % 8) == 0),
           0, 0, 0, "long_hold", i);
    end
    chk_val(4'h0, "long_hold_load_val");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
